id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Decode-to-execute pipeline stage between instruction decode and the ALU. It drives the register-file read addresses and captures the two 32-bit source operands into an execute-side register. Operands are bypassed from the MEM and WB stages. The stage stalls one cycle on a read-after-write dependency against the instruction it currently holds, and supports a valid/ready handshake plus branch flush.

## Interface
Parameters
- XLEN, 32, data width
- AW, 5, register address width (32 registers, x0 hard-wired zero)

Ports
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts it this cycle
- id_rs1, id_rs2  in  AW  source register addresses
- id_use_rs1, id_use_rs2  in  1  source actually read
- id_rd  in  AW  destination address
- id_rd_we  in  1  instruction writes rd
- id_imm  in  XLEN  decoded immediate
- id_alu_op  in  4  ALU operation code
- id_use_imm  in  1  operand B = immediate
- ra1, ra2  out  AW  register-file read addresses (= id_rs1, id_rs2, combinational)
- rd1, rd2  in  XLEN  register-file read data (combinational, x0 reads 0)
- mem_we  in  1  MEM stage will write a register
- mem_rd  in  AW  MEM destination
- mem_result  in  XLEN  MEM final result (load data included)
- wb_we  in  1  write enable currently driven to the register file
- wb_wa  in  AW  write address currently driven to the register file
- wb_wd  in  XLEN  write data currently driven to the register file
- flush  in  1  discard held and incoming instruction
- ex_valid  out  1  execute register holds an instruction
- ex_ready  in  1  execute consumes it this cycle
- ex_op_a, ex_op_b  out  XLEN  ALU operands
- ex_rs2_data  out  XLEN  forwarded rs2 value (store data)
- ex_rd, ex_rd_we, ex_alu_op  out  AW/1/4  registered control

## Operation
- Forwarding mux, per source (src1 and src2), evaluated in priority order:
  1. Address 0 → 0.
  2. mem_we and mem_rd == addr and mem_rd != 0 → mem_result.
  3. wb_we and wb_wa == addr and wb_wa != 0 → wb_wd. This covers the register-file same-edge write not yet visible on rd1/rd2.
  4. Otherwise rd1 or rd2.
- hazard = ex_valid & ex_rd_we & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- can_advance = ~ex_valid | ex_ready.
- id_ready = can_advance & ~hazard & ~flush.
- Register update, in priority order:
  - flush: ex_valid ← 0.
  - Else if id_valid & id_ready: load the entry.
    - ex_op_a ← fwd1.
    - ex_op_b ← id_use_imm ? id_imm : fwd2.
    - ex_rs2_data ← fwd2.
    - ex_rd, ex_rd_we, ex_alu_op ← the id_* values.
    - ex_valid ← 1.
  - Else if can_advance: ex_valid ← 0. This is a bubble, inserted on hazard or when no input is presented.
  - Else: hold all registers.
- Payload registers update only on accept; on a bubble they keep their values, and ex_valid alone qualifies them.
- Held operands never re-sample. They were final at capture because every older producer was then in MEM/WB or already committed.
- After one bubble, the producer sits in MEM and is forwarded from mem_result.

## Timing
- Reset (async assert, sync release): ex_valid = 0; ex_op_a, ex_op_b, ex_rs2_data = 0; ex_rd = 0; ex_rd_we = 0; ex_alu_op = 0.
- id_ready and ra1/ra2 are combinational. All ex_* outputs are registered; latency is 1 cycle from accept.
- Dependent back-to-back pair: exactly 1 bubble cycle, provided ex_ready = 1.
- flush asserted with a simultaneous id_valid: input not accepted (id_ready = 0); ex_valid = 0 next cycle.
- ex_ready = 0 with ex_valid = 1: stage frozen, id_ready = 0, outputs stable.
- Reset mid-stall or mid-flush: state clears immediately; the first accept is possible in the cycle after rst_n rises.
- A write to x0 is never forwarded.

## Test plan
- **Reset:** hold rst_n = 0 with id_valid = 1 → ex_valid = 0, all ex_* = 0. First cycle after release, id_ready = 1; the entry appears on the next edge.
- **Independent stream:** issue 3 instructions with no RAW, ex_ready = 1. Example: rs1 = 3, rd1 = 0x11 → ex_op_a = 0x11 one cycle later. ex_valid stays high with no bubbles.
- **EX-dependency stall:**
  - Instruction A writes x5; instruction B reads x5.
  - Expected: id_ready = 0 for one cycle, then a bubble.
  - B is captured with ex_op_a = mem_result = 0xDEADBEEF while rd1 = 0 (stale).
- **Forward priority:** mem_rd = wb_wa = 7, mem_result = 0xAAAA, wb_wd = 0xBBBB, rs1 = 7 → ex_op_a = 0xAAAA. With mem_we = 0 → 0xBBBB. With rs1 = 0 → 0.
- **Backpressure:** ex_ready = 0 for 4 cycles while holding op_a = 0x1234 → outputs constant, id_ready = 0. Release ex_ready → next instruction accepted on that edge.
- **Flush:** flush = 1 together with id_valid = 1 → entry discarded, ex_valid = 0 next cycle. An instruction presented the following cycle is accepted normally.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register with MEM/WB operand
// forwarding, a one-cycle RAW stall against the held instruction, a
// valid/ready handshake on both sides and a branch flush.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and ready are both high. The producer keeps its payload
// stable while valid is high and ready is low. ready may depend
// combinationally on the current inputs.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    // decode side
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic            id_use_imm,

    // register file read ports
    output logic [AW-1:0]   ra1,
    output logic [AW-1:0]   ra2,
    input  logic [XLEN-1:0] rd1,
    input  logic [XLEN-1:0] rd2,

    // forwarding sources
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_result,
    input  logic            wb_we,
    input  logic [AW-1:0]   wb_wa,
    input  logic [XLEN-1:0] wb_wd,

    // pipeline control
    input  logic            flush,

    // execute side
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_we,
    output logic [3:0]      ex_alu_op
);

    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            hazard;
    logic            can_advance;
    logic            accept;

    // Register-file addresses come straight from decode.
    assign ra1 = id_rs1;
    assign ra2 = id_rs2;

    // Bypass selection: the youngest producer (MEM) wins over WB, WB covers
    // the register-file write landing on the same edge, x0 is never bypassed.
    function automatic logic [XLEN-1:0] bypass(
        input logic [AW-1:0]   addr,
        input logic [XLEN-1:0] rf_data
    );
        logic [XLEN-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (mem_we && (mem_rd == addr) && (mem_rd != '0)) begin
            val = mem_result;
        end else if (wb_we && (wb_wa == addr) && (wb_wa != '0)) begin
            val = wb_wd;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Forwarded source operands for the instruction currently in decode.
    always_comb begin
        fwd1 = bypass(id_rs1, rd1);
        fwd2 = bypass(id_rs2, rd2);
    end

    // The held instruction's result is not available anywhere yet, so a
    // reader of its rd must wait until it has moved on to MEM.
    always_comb begin
        hazard = 1'b0;
        if (ex_valid && ex_rd_we && (ex_rd != '0)) begin
            hazard = (id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd));
        end
        can_advance = !ex_valid || ex_ready;
        id_ready    = can_advance && !hazard && !flush;
        accept      = id_valid && id_ready;
    end

    // Valid bit: flush wins, then accept, then bubble when the slot drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (can_advance) begin
            ex_valid <= 1'b0;
        end
    end

    // Payload loads only on accept; operands are final at capture and are
    // never re-sampled while held, ex_valid alone qualifies them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_op_a     <= '0;
            ex_op_b     <= '0;
            ex_rs2_data <= '0;
            ex_rd       <= '0;
            ex_rd_we    <= 1'b0;
            ex_alu_op   <= '0;
        end else if (!flush && accept) begin
            ex_op_a     <= fwd1;
            ex_op_b     <= id_use_imm ? id_imm : fwd2;
            ex_rs2_data <= fwd2;
            ex_rd       <= id_rd;
            ex_rd_we    <= id_rd_we;
            ex_alu_op   <= id_alu_op;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios with literal expectations plus a long
// randomized run, all checked against a behavioural model of the stage and
// a bench-owned register file.
module tb_id_ex_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            id_valid, id_ready;
  logic [AW-1:0]   id_rs1, id_rs2, id_rd;
  logic            id_use_rs1, id_use_rs2, id_rd_we, id_use_imm;
  logic [XLEN-1:0] id_imm;
  logic [3:0]      id_alu_op;
  logic [AW-1:0]   ra1, ra2;
  logic [XLEN-1:0] rd1, rd2;
  logic            mem_we, wb_we;
  logic [AW-1:0]   mem_rd, wb_wa;
  logic [XLEN-1:0] mem_result, wb_wd;
  logic            flush;
  logic            ex_valid, ex_ready;
  logic [XLEN-1:0] ex_op_a, ex_op_b, ex_rs2_data;
  logic [AW-1:0]   ex_rd;
  logic            ex_rd_we;
  logic [3:0]      ex_alu_op;

  id_ex_stage #(.XLEN(XLEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_rd_we(id_rd_we), .id_imm(id_imm),
    .id_alu_op(id_alu_op), .id_use_imm(id_use_imm),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .mem_we(mem_we), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_rs2_data(ex_rs2_data),
    .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_alu_op(ex_alu_op)
  );

  // ---------------- bench register file ----------------
  logic [XLEN-1:0] regs [32];
  assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Expected contents of the execute register.
  logic            m_valid;
  logic [XLEN-1:0] m_a, m_b, m_s2;
  logic [AW-1:0]   m_rd;
  logic            m_we;
  logic [3:0]      m_op;

  // Value an operand must have: x0 is zero, then the newest pending write
  // to that register (MEM before WB), otherwise the architectural register.
  function automatic logic [XLEN-1:0] src_value(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (mem_we && mem_rd == a) return mem_result;
    if (wb_we && wb_wa == a) return wb_wd;
    return regs[a];
  endfunction

  // The decode instruction may enter only if the slot will be free, it does
  // not read what the held instruction is about to write, and no flush.
  function automatic logic model_ready();
    logic waits_on_ex;
    logic slot_free;
    waits_on_ex = m_valid && m_we && m_rd != 0 &&
                  ((id_use_rs1 && id_rs1 == m_rd) || (id_use_rs2 && id_rs2 == m_rd));
    slot_free = !m_valid || ex_ready;
    return slot_free && !waits_on_ex && !flush;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_a = '0; m_b = '0; m_s2 = '0; m_rd = '0; m_we = 0; m_op = '0;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, ".ex_valid"},    XLEN'(ex_valid),    XLEN'(m_valid));
    if (m_valid) begin
      chk({tag, ".ex_op_a"},     ex_op_a,            m_a);
      chk({tag, ".ex_op_b"},     ex_op_b,            m_b);
      chk({tag, ".ex_rs2_data"}, ex_rs2_data,        m_s2);
      chk({tag, ".ex_rd"},       XLEN'(ex_rd),       XLEN'(m_rd));
      chk({tag, ".ex_rd_we"},    XLEN'(ex_rd_we),    XLEN'(m_we));
      chk({tag, ".ex_alu_op"},   XLEN'(ex_alu_op),   XLEN'(m_op));
    end
  endtask

  // One clock: check combinational outputs, predict the next state, take
  // the edge, apply the register-file write, check the registered outputs.
  task automatic tick(input string tag);
    logic            rdy;
    logic            slot_free;
    logic [XLEN-1:0] v1, v2;
    #1;
    rdy = model_ready();
    slot_free = !m_valid || ex_ready;
    chk({tag, ".id_ready"}, XLEN'(id_ready), XLEN'(rdy));
    chk({tag, ".ra1"}, XLEN'(ra1), XLEN'(id_rs1));
    chk({tag, ".ra2"}, XLEN'(ra2), XLEN'(id_rs2));
    v1 = src_value(id_rs1);
    v2 = src_value(id_rs2);
    @(posedge clk);
    if (flush) begin
      m_valid = 0;
    end else if (id_valid && rdy) begin
      m_valid = 1;
      m_a  = v1;
      m_b  = id_use_imm ? id_imm : v2;
      m_s2 = v2;
      m_rd = id_rd; m_we = id_rd_we; m_op = id_alu_op;
    end else if (slot_free) begin
      m_valid = 0;
    end
    if (wb_we && wb_wa != 0) regs[wb_wa] = wb_wd;
    #1;
    check_regs(tag);
  endtask

  // ---------------- driver tasks ----------------
  task automatic quiet_fwd();
    mem_we = 0; mem_rd = '0; mem_result = '0;
    wb_we = 0; wb_wa = '0; wb_wd = '0;
  endtask

  task automatic drive_instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                             input logic [AW-1:0] rd, input logic we,
                             input logic [3:0] op, input logic use_imm,
                             input logic [XLEN-1:0] imm);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2;
    id_use_rs1 = 1; id_use_rs2 = !use_imm;
    id_rd = rd; id_rd_we = we; id_alu_op = op; id_use_imm = use_imm; id_imm = imm;
  endtask

  task automatic drive_random();
    id_valid   = ($urandom_range(0, 3) != 0);
    id_rs1     = AW'($urandom_range(0, 7));
    id_rs2     = AW'($urandom_range(0, 7));
    id_use_rs1 = ($urandom_range(0, 3) != 0);
    id_use_rs2 = $urandom_range(0, 1) != 0;
    id_rd      = AW'($urandom_range(0, 7));
    id_rd_we   = ($urandom_range(0, 3) != 0);
    id_imm     = $urandom;
    id_alu_op  = 4'($urandom_range(0, 15));
    id_use_imm = $urandom_range(0, 1) != 0;
    mem_we     = $urandom_range(0, 1) != 0;
    mem_rd     = AW'($urandom_range(0, 7));
    mem_result = $urandom;
    wb_we      = $urandom_range(0, 1) != 0;
    wb_wa      = AW'($urandom_range(0, 7));
    wb_wd      = $urandom;
    ex_ready   = ($urandom_range(0, 3) != 0);
    flush      = ($urandom_range(0, 15) == 0);
  endtask

  task automatic apply_reset();
    rst_n = 0;
    #1;
    model_clear();
    check_regs("reset_async");
    chk("reset.ex_op_a", ex_op_a, 32'h0);
    chk("reset.ex_rd_we", XLEN'(ex_rd_we), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold.ex_valid", XLEN'(ex_valid), 32'h0);
    rst_n = 1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = XLEN'($urandom);
    regs[3] = 32'h11;
    quiet_fwd();
    flush = 0; ex_ready = 1;
    drive_instr(5'd3, 5'd2, 5'd10, 1'b1, 4'd1, 1'b0, 32'h0);
    model_clear();

    // Reset with an instruction presented.
    @(posedge clk); #1;
    apply_reset();
    #1;
    chk("post_reset.id_ready", XLEN'(id_ready), 32'h1);
    tick("post_reset");
    chk("post_reset.ex_op_a", ex_op_a, 32'h11);
    chk("post_reset.ex_valid", XLEN'(ex_valid), 32'h1);

    // Independent stream: no reader of the previous rd.
    drive_instr(5'd1, 5'd2, 5'd11, 1'b1, 4'd2, 1'b0, 32'h0);
    tick("indep1");
    drive_instr(5'd3, 5'd4, 5'd12, 1'b1, 4'd3, 1'b1, 32'h55);
    tick("indep2");
    chk("indep2.ex_op_b_imm", ex_op_b, 32'h55);
    drive_instr(5'd6, 5'd7, 5'd13, 1'b1, 4'd4, 1'b0, 32'h0);
    tick("indep3");
    chk("indep3.ex_valid", XLEN'(ex_valid), 32'h1);

    // EX dependency: A writes x5, B reads x5.
    regs[5] = 32'h0;
    drive_instr(5'd1, 5'd2, 5'd5, 1'b1, 4'd5, 1'b0, 32'h0);
    tick("raw_a");
    drive_instr(5'd5, 5'd0, 5'd9, 1'b0, 4'd6, 1'b1, 32'h4);
    #1;
    chk("raw_stall.id_ready", XLEN'(id_ready), 32'h0);
    tick("raw_stall");
    chk("raw_bubble.ex_valid", XLEN'(ex_valid), 32'h0);
    mem_we = 1; mem_rd = 5'd5; mem_result = 32'hDEADBEEF;
    #1;
    chk("raw_go.id_ready", XLEN'(id_ready), 32'h1);
    tick("raw_b");
    chk("raw_b.ex_op_a", ex_op_a, 32'hDEADBEEF);

    // Forward priority on x7.
    mem_we = 1; mem_rd = 5'd7; mem_result = 32'hAAAA;
    wb_we = 1; wb_wa = 5'd7; wb_wd = 32'hBBBB;
    drive_instr(5'd7, 5'd1, 5'd9, 1'b0, 4'd1, 1'b0, 32'h0);
    tick("fwd_mem");
    chk("fwd_mem.ex_op_a", ex_op_a, 32'hAAAA);
    mem_we = 0;
    tick("fwd_wb");
    chk("fwd_wb.ex_op_a", ex_op_a, 32'hBBBB);
    id_rs1 = 5'd0;
    tick("fwd_x0");
    chk("fwd_x0.ex_op_a", ex_op_a, 32'h0);

    // A write to x0 is never forwarded.
    quiet_fwd();
    mem_we = 1; mem_rd = 5'd0; mem_result = 32'h77;
    drive_instr(5'd0, 5'd0, 5'd9, 1'b0, 4'd1, 1'b0, 32'h0);
    tick("wr_x0");
    chk("wr_x0.ex_rs2_data", ex_rs2_data, 32'h0);

    // Backpressure while holding op_a = 0x1234.
    quiet_fwd();
    regs[4] = 32'h1234;
    drive_instr(5'd4, 5'd1, 5'd9, 1'b0, 4'd7, 1'b0, 32'h0);
    tick("bp_load");
    ex_ready = 0;
    drive_instr(5'd3, 5'd2, 5'd8, 1'b1, 4'd8, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("bp.id_ready", XLEN'(id_ready), 32'h0);
      tick("bp_hold");
      chk("bp.ex_op_a", ex_op_a, 32'h1234);
      chk("bp.ex_valid", XLEN'(ex_valid), 32'h1);
    end
    ex_ready = 1;
    #1;
    chk("bp_release.id_ready", XLEN'(id_ready), 32'h1);
    tick("bp_release");
    chk("bp_release.ex_op_a", ex_op_a, 32'h11);

    // Flush with simultaneous id_valid.
    flush = 1;
    drive_instr(5'd1, 5'd2, 5'd9, 1'b1, 4'd9, 1'b0, 32'h0);
    #1;
    chk("flush.id_ready", XLEN'(id_ready), 32'h0);
    tick("flush");
    chk("flush.ex_valid", XLEN'(ex_valid), 32'h0);
    flush = 0;
    drive_instr(5'd3, 5'd2, 5'd9, 1'b1, 4'd9, 1'b0, 32'h0);
    tick("after_flush");
    chk("after_flush.ex_valid", XLEN'(ex_valid), 32'h1);

    // Randomized run with a reset in the middle.
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      if (c == 1500) begin
        apply_reset();
      end
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
